// File: rtl/uart_tx_periph_if.sv
// CPU data-bus view of the UART transmitter: address/data/store strobe in, status word out.
interface uart_tx_periph_if;
    logic [9:0]  address;
    logic [31:0] data;
    logic        write;
    logic [31:0] status;

    modport master (output address, output data, output write, input status);
    modport slave  (input address, input data, input write, output status);
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: CPU stores fill a TX FIFO, a baud-timed FSM emits 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_periph #(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [9:0] BASE_ADDR    = 10'h3F8
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_periph_if.slave bus,
    output logic            tx,
    output logic            busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [9:0]    STATUS_ADDR = BASE_ADDR + 10'd4;
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic empty, full, push_req, push, pop, clr_req, baud_done;
    logic [7:0] count_ext;
    logic [3:0] count_sat;

    // FIFO bookkeeping and sticky overflow; a pop in the same cycle frees room for a push into a full FIFO.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == COUNT_FULL);
        baud_done = (baud_q == BAUD_LAST);
        push_req  = bus.write && (bus.address == BASE_ADDR);
        clr_req   = bus.write && (bus.address == STATUS_ADDR) && bus.data[0];
        pop       = (state_q == IDLE) && !empty;
        push      = push_req && (!full || pop);
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (push_req && !push) begin
            overflow_d = 1'b1;
        end else if (clr_req) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!empty) state_d = START;
            START: if (baud_done) state_d = DATA;
            DATA: begin
                if (baud_done && bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_done) state_d = STOP;
`endif
            STOP:  if (baud_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the same edge as the state.
    always_comb begin
        baud_d    = (state_q == IDLE || baud_done) ? '0 : baud_q + BW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (pop) begin
            shift_d   = fifo_mem_q[rd_ptr_q];
            bit_idx_d = '0;
        end else if (state_q == DATA && baud_done) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
        end
`ifdef UART_TX_PARITY_EN
        parity_d = pop ? ^fifo_mem_q[rd_ptr_q] : parity_q;
`endif
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset; the control state above decides what is valid.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bus.data[7:0];
        end
    end

    assign count_ext  = 8'(count_q);
    assign count_sat  = (count_ext > 8'd15) ? 4'hF : count_ext[3:0];
    assign busy       = (state_q != IDLE) || !empty;
    assign tx         = tx_q;
    assign bus.status = {24'b0, count_sat, overflow_q, busy, empty, full};
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: bus-op vector table, frame-decoding monitor with byte scoreboard.
module tb_uart_tx_periph;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy;

    uart_tx_periph_if bus_if ();

    uart_tx_periph #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (10'h3F8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sb_q[$];
    bit mon_en = 1'b0;
    bit in_frame = 1'b0;
    int frames_seen = 0;
    int start_prev = 0;
    int start_last = 0;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_status;
        bit          accept;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
        bus_if.address = a;
        bus_if.data    = d;
        bus_if.write   = 1'b1;
        @(posedge clk);
        #1 bus_if.write = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
            done = (busy === 1'b0) && !in_frame && (sb_q.size() == 0);
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: still busy after %0d cycles, %0d bytes pending", name, n, sb_q.size());
        end
    endtask

    // Decodes each frame by sampling mid-bit and compares it with the oldest queued byte.
    initial begin : monitor
        logic [NBITS-1:0] got;
        logic [NBITS-1:0] expv;
        logic [7:0] b;
        bit aborted;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                in_frame = 1'b1;
                aborted = 1'b0;
                got = '0;
                frames_seen++;
                start_prev = start_last;
                start_last = cyc;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % CPB == CPB / 2) got[c/CPB] = tx;
                end
                if (!aborted) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL frame: got frame bits 0x%0h with no byte expected", got);
                    end else begin
                        b = sb_q.pop_front();
`ifdef UART_TX_PARITY_EN
                        expv = {1'b1, ^b, b, 1'b0};
`else
                        expv = {1'b1, b, 1'b0};
`endif
                        check($sformatf("frame byte 0x%0h", b), 32'(got), 32'(expv));
                    end
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached with %0d tests run", tests);
        $fatal(1);
    end

    initial begin : stim
        int fs;
        bit low_seen;

        vecs[0]  = '{1'b1, 10'h3F8, 32'hFFFF_FFA0, 32'h14, 1'b1};
        vecs[1]  = '{1'b1, 10'h3F8, 32'h0000_00A1, 32'h14, 1'b1};
        vecs[2]  = '{1'b1, 10'h3F8, 32'h0000_00A2, 32'h24, 1'b1};
        vecs[3]  = '{1'b1, 10'h3F8, 32'h0000_00A3, 32'h34, 1'b1};
        vecs[4]  = '{1'b1, 10'h3F8, 32'h0000_00A4, 32'h44, 1'b1};
        vecs[5]  = '{1'b1, 10'h3F8, 32'h0000_00A5, 32'h54, 1'b1};
        vecs[6]  = '{1'b1, 10'h3F8, 32'h0000_00A6, 32'h64, 1'b1};
        vecs[7]  = '{1'b1, 10'h3F8, 32'h0000_00A7, 32'h74, 1'b1};
        vecs[8]  = '{1'b1, 10'h3F8, 32'h0000_00A8, 32'h85, 1'b1};
        vecs[9]  = '{1'b1, 10'h3F8, 32'h0000_00A9, 32'h8D, 1'b0};
        vecs[10] = '{1'b1, 10'h3FC, 32'h0000_0001, 32'h85, 1'b0};
        vecs[11] = '{1'b1, 10'h3F0, 32'h0000_0099, 32'h85, 1'b0};
        vecs[12] = '{1'b1, 10'h3FC, 32'h0000_0000, 32'h85, 1'b0};
        vecs[13] = '{1'b0, 10'h3F8, 32'h0000_0077, 32'h85, 1'b0};

        bus_if.address = '0;
        bus_if.data    = '0;
        bus_if.write   = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle tx", 32'(tx), 32'h1);
        check("idle status", bus_if.status, 32'h2);
        check("idle busy", 32'(busy), 32'h0);
        mon_en = 1'b1;

        // Single frame: latency, frame length via busy
        sb_q.push_back(8'h55);
        bus_write(10'h3F8, 32'h55);
        @(negedge clk);
        check("tx high on write edge", 32'(tx), 32'h1);
        check("busy after write", 32'(busy), 32'h1);
        @(negedge clk);
        check("tx start after pop", 32'(tx), 32'h0);
        repeat (FRAME - 1) @(negedge clk);
        check("busy in last stop cycle", 32'(busy), 32'h1);
        @(negedge clk);
        check("busy after frame", 32'(busy), 32'h0);
        wait_idle("frame 0x55", 4 * FRAME);

        // Back-to-back frames
        sb_q.push_back(8'h01);
        sb_q.push_back(8'h80);
        bus_write(10'h3F8, 32'h01);
        bus_write(10'h3F8, 32'h80);
        wait_idle("frames 0x01 0x80", 4 * FRAME);
        check("back-to-back start spacing", 32'(start_last - start_prev), 32'(FRAME + 1));

        // Vector table: fill, overflow, clear, ignored ops
        for (int i = 0; i < 14; i++) begin
            bus_if.write   = vecs[i].wr;
            bus_if.address = vecs[i].addr;
            bus_if.data    = vecs[i].data;
            if (vecs[i].wr && vecs[i].accept) sb_q.push_back(vecs[i].data[7:0]);
            @(posedge clk);
            #1 bus_if.write = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d status", i), bus_if.status, vecs[i].exp_status);
        end
        wait_idle("drain nine bytes", 10 * (FRAME + 1) + 50);
        check("status after drain", bus_if.status, 32'h2);

        // Asynchronous reset in the middle of a data bit with bytes queued
        for (int i = 0; i < 4; i++) bus_write(10'h3F8, 32'(8'hC0 + i));
        repeat (12) @(negedge clk);
        check("tx low before reset", 32'(tx), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("tx on async reset", 32'(tx), 32'h1);
        check("busy on async reset", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        fs = frames_seen;
        @(negedge clk);
        check("status after reset", bus_if.status, 32'h2);
        low_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("no frame after reset", 32'(frames_seen), 32'(fs));
        check("tx stays idle after reset", 32'(low_seen), 32'h0);

`ifdef UART_TX_PARITY_EN
        // Parity frame: 0x07 has odd weight, parity bit is 1
        sb_q.push_back(8'h07);
        bus_write(10'h3F8, 32'h07);
        wait_idle("parity frame 0x07", 4 * FRAME);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
